// File: rtl/baccarat_round_fsm.sv
// -----------------------------------------------------------------------------
// baccarat_round_fsm
//   Round controller for the baccarat datapath. It deals two cards to each
//   side, then applies the natural, player-draw and banker third-card rules
//   using the totals from the hand scorers. When the round is over it latches
//   the win lights and waits for new_round.
//
// Ports
//   slow_clock        in   game step clock (rising edge)
//   reset             in   synchronous active-high; back to the first deal
//   pscore / dscore   in   hand totals from the scorers (0..9)
//   pcard3            in   player third-card rank (1..13, 0 = none)
//   new_round         in   level, only looked at in DONE
//   load_pcard1..3    out  player card-register load strobes
//   load_dcard1..3    out  dealer card-register load strobes
//   clear_hand        out  card-register clear strobe
//   player_win_light  out  registered win light
//   dealer_win_light  out  registered win light (a tie lights both)
//   done              out  high while the finished round is shown
// -----------------------------------------------------------------------------
module baccarat_round_fsm (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       new_round,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clear_hand,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  typedef enum logic [3:0] {
    ST_P1     = 4'd0,
    ST_D1     = 4'd1,
    ST_P2     = 4'd2,
    ST_D2     = 4'd3,
    ST_CHECK  = 4'd4,
    ST_P3     = 4'd5,
    ST_BDEC   = 4'd6,
    ST_D3     = 4'd7,
    ST_RESULT = 4'd8,
    ST_DONE   = 4'd9,
    ST_CLEAR  = 4'd10
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   player_next_s;
  logic   dealer_next_s;

  // Banker third-card table. Face cards and tens count as zero.
  function automatic logic banker_draws_f(input logic [3:0] d, input logic [3:0] c3);
    logic [3:0] v;
    v = (c3 >= 4'd10) ? 4'd0 : c3;
    case (d)
      4'd0, 4'd1, 4'd2: banker_draws_f = 1'b1;
      4'd3:             banker_draws_f = (v != 4'd8);
      4'd4:             banker_draws_f = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             banker_draws_f = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             banker_draws_f = (v >= 4'd6) && (v <= 4'd7);
      default:          banker_draws_f = 1'b0;
    endcase
  endfunction

  // Next-state and next-light logic.
  always_comb begin
    state_next_s  = state_r;
    player_next_s = player_win_light;
    dealer_next_s = dealer_win_light;
    case (state_r)
      ST_P1:    state_next_s = ST_D1;
      ST_D1:    state_next_s = ST_P2;
      ST_P2:    state_next_s = ST_D2;
      ST_D2:    state_next_s = ST_CHECK;
      ST_CHECK: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          state_next_s = ST_RESULT;
        end else if (pscore <= 4'd5) begin
          state_next_s = ST_P3;
        end else if (dscore <= 4'd5) begin
          state_next_s = ST_D3;
        end else begin
          state_next_s = ST_RESULT;
        end
      end
      ST_P3:    state_next_s = ST_BDEC;
      ST_BDEC: begin
        if (banker_draws_f(dscore, pcard3)) begin
          state_next_s = ST_D3;
        end else begin
          state_next_s = ST_RESULT;
        end
      end
      ST_D3:    state_next_s = ST_RESULT;
      ST_RESULT: begin
        state_next_s  = ST_DONE;
        player_next_s = (pscore >= dscore);
        dealer_next_s = (dscore >= pscore);
      end
      ST_DONE: begin
        if (new_round) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_CLEAR: begin
        state_next_s  = ST_P1;
        player_next_s = 1'b0;
        dealer_next_s = 1'b0;
      end
      default: begin
        state_next_s  = ST_P1;
        player_next_s = 1'b0;
        dealer_next_s = 1'b0;
      end
    endcase
  end

  // State, lights and strobes. Strobes are decoded from the next state so
  // that each one is registered yet high exactly while its state is current.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_r          <= ST_P1;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      load_pcard1      <= 1'b1;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      clear_hand       <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      player_win_light <= player_next_s;
      dealer_win_light <= dealer_next_s;
      load_pcard1      <= (state_next_s == ST_P1);
      load_pcard2      <= (state_next_s == ST_P2);
      load_pcard3      <= (state_next_s == ST_P3);
      load_dcard1      <= (state_next_s == ST_D1);
      load_dcard2      <= (state_next_s == ST_D2);
      load_dcard3      <= (state_next_s == ST_D3);
      clear_hand       <= (state_next_s == ST_CLEAR);
      done             <= (state_next_s == ST_DONE);
    end
  end

endmodule

// File: doc/baccarat_round_fsm.md
# baccarat_round_fsm

Round controller for the baccarat datapath. It sequences dealing of player and dealer cards by pulsing per-slot load strobes into the card registers. It reads back the hand totals produced by the two hand-scoring blocks and applies the natural, player-draw and banker third-card rules. Once the round completes it drives the win lights. It sits directly downstream of the hand-scoring blocks and upstream of the card registers, closing the deal loop.

## Interface
- No parameters.
- slow_clock  in  1  single clock; one game step per rising edge
- reset  in  1  synchronous, active-high; returns FSM to first deal state
- pscore  in  4  player hand total from scorer, 0–9
- dscore  in  4  dealer hand total from scorer, 0–9
- pcard3  in  4  player third-card rank, 1–13 (0 = no card)
- new_round  in  1  level; sampled only in DONE
- load_pcard1/2/3  out  1 each  Moore strobe; card register latches on edge ending state
- load_dcard1/2/3  out  1 each  same for dealer slots
- clear_hand  out  1  Moore strobe; card registers zero on edge ending state
- player_win_light  out  1  registered
- dealer_win_light  out  1  registered
- done  out  1  Moore; high in DONE

## Operation
- States: P1, D1, P2, D2, CHECK, P3, BDEC, D3, RESULT, DONE, CLEAR.
- Strobe outputs decode from state. At most one of the 7 strobes is high in any cycle. Each strobe is high in exactly its own state.
- Fixed deal order: P1→D1→P2→D2→CHECK.
- CHECK:
  - pscore≥8 or dscore≥8 (natural) → RESULT.
  - Else pscore≤5 → P3.
  - Else (player stands on 6/7) dscore≤5 → D3, else → RESULT.
- P3 → BDEC. In BDEC, pcard3 is valid. v = 0 if pcard3≥10, else pcard3.
- BDEC, banker draws (→D3) when any of:
  - dscore≤2
  - dscore=3 and v≠8
  - dscore=4 and v∈2..7
  - dscore=5 and v∈4..7
  - dscore=6 and v∈6..7
- BDEC, otherwise → RESULT (dscore=7 always stands).
- D3 → RESULT.
- RESULT → DONE. On that edge:
  - player_win_light ← (pscore≥dscore)
  - dealer_win_light ← (dscore≥pscore)
  - A tie lights both.
- DONE: hold lights. new_round=1 → CLEAR, else stay.
- CLEAR: clear_hand=1. On exit, both lights ← 0. → P1.
- Unused state encodings → P1 with lights cleared.
- Scores are compared unsigned 4-bit. Inputs >9 are out of contract; no checking.

## Timing
- Reset values:
  - State = P1.
  - load_pcard1=1; all other strobes = 0.
  - clear_hand=0, done=0, both lights=0.
- Reset wins over every transition, including mid-deal and in DONE. It takes effect on the next edge with no partial state retained.
- pscore/dscore/pcard3 are sampled in CHECK, BDEC and RESULT, one full cycle after the last load edge. Scorer combinational delay must fit one slow_clock period.
- Cycle counts from the first edge with reset low, with n = index of edge entering DONE:
  - No draws: n=6.
  - Player draws only: n=8 (P3, BDEC added).
  - Banker-only draw: n=7.
  - Both draw: n=9.
- Lights become valid in the same cycle done rises, and stay stable until CLEAR exits.
- new_round held high while in DONE gives exactly one CLEAR cycle, then a new deal. A new_round level outside DONE is ignored.

## Test plan
- Natural: pscore=9, dscore=7 at CHECK → RESULT next, no P3/D3 strobe, done at edge 6, player_win=1, dealer_win=0.
- Player draws, banker stands: pscore=4 at CHECK; at BDEC dscore=6, pcard3=8 (v=8) → no D3, RESULT. With pscore=5 final: dealer_win=1, player_win=0, done at edge 8.
- Banker 3-vs-8 rule: dscore=3, pcard3=8 → stands. Repeat with pcard3=12 (v=0) → load_dcard3 pulses exactly one cycle, done at edge 9.
- Player stands, banker draws: pscore=7, dscore=5 at CHECK → D3, no P3. Final pscore=7, dscore=7 → both lights 1, done at edge 7.
- Reset mid-round: assert reset in BDEC → next cycle load_pcard1=1, lights 0, done 0. Full round then replays normally.
- Replay: in DONE hold new_round=0 for 5 cycles (lights stable), then 1 → clear_hand high one cycle, lights 0, then load_pcard1.
